// File: rtl/deserializer_pkg.sv
// Shared defaults and types for the serial-link deserializer.
package deser_pkg;

  localparam int DATA_W  = 16;
  localparam int MOD_W   = 4;
  localparam int MIN_LEN = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [MOD_W-1:0] MOD_FULL = '0;

endpackage

// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bundle of the deserializer; master drives the serial side.
interface deserializer_if #(
  parameter int DATA_W = deser_pkg::DATA_W,
  parameter int MOD_W  = deser_pkg::MOD_W
) ();

  logic              ser_data_i;
  logic              ser_data_val_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_data_mod_o;
  logic              deser_data_val_o;
  logic              busy_o;

  modport master (
    output ser_data_i, ser_data_val_i,
    input  deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o
  );

  modport slave (
    input  ser_data_i, ser_data_val_i,
    output deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o
  );

endinterface

// File: rtl/deserializer.sv
// MSB-first serial to DATA_W-bit parallel converter with a one-cycle word strobe.
// Optional macro DESER_GAP_FLUSH_EN: an invalid cycle closes (or drops) a partial word.
module deserializer #(
  parameter int DATA_W  = deser_pkg::DATA_W,
  parameter int MOD_W   = deser_pkg::MOD_W,
  parameter int MIN_LEN = deser_pkg::MIN_LEN
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  deserializer_if.slave bus
);
  import deser_pkg::*;

  localparam logic [MOD_W:0] CNT_LAST = (MOD_W+1)'(DATA_W - 1);
  localparam logic [MOD_W:0] CNT_MIN  = (MOD_W+1)'(MIN_LEN);

  if (MOD_W != $clog2(DATA_W) || MIN_LEN < 1 || MIN_LEN >= DATA_W || DATA_W < 3) begin : g_param_chk
    $error("deserializer: inconsistent DATA_W / MOD_W / MIN_LEN");
  end

  // The newest bit goes straight into the output word, so only DATA_W-1 bits are stored.
  state_t            state;
  logic [DATA_W-2:0] shreg;
  logic [MOD_W:0]    cnt;

`ifdef DESER_GAP_FLUSH_EN
  function automatic logic [DATA_W-1:0] left_align(input logic [DATA_W-2:0] bits,
                                                    input logic [MOD_W:0]    n);
    return {bits, 1'b0} << (DATA_W - 1 - int'(n));
  endfunction
`endif

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state                <= IDLE;
      shreg                <= '0;
      cnt                  <= '0;
      bus.deser_data_o     <= '0;
      bus.deser_data_mod_o <= '0;
      bus.deser_data_val_o <= 1'b0;
      bus.busy_o           <= 1'b0;
    end else begin
      bus.deser_data_val_o <= 1'b0;
      if (bus.ser_data_val_i) begin
        shreg <= {shreg[DATA_W-3:0], bus.ser_data_i};
        if (state == COLLECT && cnt == CNT_LAST) begin
          bus.deser_data_o     <= {shreg, bus.ser_data_i};
          bus.deser_data_mod_o <= MOD_W'(MOD_FULL);
          bus.deser_data_val_o <= 1'b1;
          cnt                  <= '0;
          bus.busy_o           <= 1'b0;
          state                <= IDLE;
        end else begin
          cnt        <= cnt + 1'b1;
          bus.busy_o <= 1'b1;
          state      <= COLLECT;
        end
      end
`ifdef DESER_GAP_FLUSH_EN
      else if (state == COLLECT) begin
        // Words shorter than MIN_LEN are protocol-illegal and are discarded silently.
        if (cnt >= CNT_MIN) begin
          bus.deser_data_o     <= left_align(shreg, cnt);
          bus.deser_data_mod_o <= cnt[MOD_W-1:0];
          bus.deser_data_val_o <= 1'b1;
        end
        cnt        <= '0;
        bus.busy_o <= 1'b0;
        state      <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer; expected words are queued as bits are driven.
module tb_deserializer;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  mod;
  } exp_t;

  logic clk;
  logic arst_n;
  int   n_checks;
  int   n_errors;
  int   cyc;
  int   strobes;
  int   last_cyc;
  int   prev_cyc;
  exp_t sb[$];

  deserializer_if #(.DATA_W(16), .MOD_W(4)) bus ();

  deserializer #(.DATA_W(16), .MOD_W(4), .MIN_LEN(3)) dut (
    .clk_i   (clk),
    .arst_n_i(arst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.deser_data_val_o === 1'b1) begin
      strobes++;
      prev_cyc = last_cyc;
      last_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word_data", 32'(bus.deser_data_o), 32'(e.data));
        check("word_mod", 32'(bus.deser_data_mod_o), 32'(e.mod));
      end
    end
  end

  task automatic drive_bit(input logic b, input logic v);
    bus.ser_data_i     = b;
    bus.ser_data_val_i = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) drive_bit(w[n-1-i], 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    n_checks = 0; n_errors = 0; cyc = 0; strobes = 0; last_cyc = 0; prev_cyc = 0;
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(bus.deser_data_o), 32'h0);
    check("rst_val", 32'(bus.deser_data_val_o), 32'h0);
    @(negedge clk);
    arst_n = 1'b1;

    // Reset idle: 20 invalid cycles produce nothing.
    idle(20);
    check("idle_data", 32'(bus.deser_data_o), 32'h0);
    check("idle_mod", 32'(bus.deser_data_mod_o), 32'h0);
    check("idle_busy", 32'(bus.busy_o), 32'h0);
    check("idle_strobes", 32'(strobes), 32'd0);

    // Full word with busy tracking and one-cycle latency.
    w = 16'hA5C3;
    sb.push_back('{data: w, mod: 4'd0});
    for (int i = 0; i < 16; i++) begin
      drive_bit(w[15-i], 1'b1);
      check($sformatf("full_busy_%0d", i + 1), 32'(bus.busy_o), (i < 15) ? 32'd1 : 32'd0);
    end
    check("full_latency", 32'(bus.deser_data_val_o), 32'd1);
    idle(1);
    check("full_one_cycle", 32'(bus.deser_data_val_o), 32'd0);
    check("full_hold", 32'(bus.deser_data_o), 32'hA5C3);
    idle(2);

    // Back-to-back words, no bubble.
    sb.push_back('{data: 16'h1234, mod: 4'd0});
    sb.push_back('{data: 16'hFFFE, mod: 4'd0});
    send_word(16'h1234, 16);
    send_word(16'hFFFE, 16);
    idle(2);
    check("b2b_spacing", 32'(last_cyc - prev_cyc), 32'd16);
    check("b2b_strobes", 32'(strobes), 32'd3);

`ifdef DESER_GAP_FLUSH_EN
    // Gap flush of a 5-bit word, then a dropped 2-bit fragment.
    sb.push_back('{data: 16'hB000, mod: 4'd5});
    send_word(16'h0016, 5);
    idle(1);
    check("flush_val", 32'(bus.deser_data_val_o), 32'd1);
    check("flush_busy", 32'(bus.busy_o), 32'd0);
    idle(2);
    send_word(16'h0003, 2);
    check("drop_busy_before", 32'(bus.busy_o), 32'd1);
    idle(1);
    check("drop_busy_after", 32'(bus.busy_o), 32'd0);
    idle(3);
    check("drop_strobes", 32'(strobes), 32'd4);
`else
    // Gaps are ignored: two 8-bit halves join into one word.
    sb.push_back('{data: 16'h3C81, mod: 4'd0});
    send_word(16'h003C, 8);
    idle(4);
    check("hold_busy", 32'(bus.busy_o), 32'd1);
    check("hold_no_strobe", 32'(strobes), 32'd3);
    send_word(16'h0081, 8);
    idle(2);
    check("hold_strobes", 32'(strobes), 32'd4);
`endif

    // Asynchronous reset mid-word.
    send_word(16'h01FF, 9);
    bus.ser_data_val_i = 1'b0;
    @(negedge clk);
    #1 arst_n = 1'b0;
    #1;
    check("amid_data", 32'(bus.deser_data_o), 32'h0);
    check("amid_busy", 32'(bus.busy_o), 32'h0);
    check("amid_mod", 32'(bus.deser_data_mod_o), 32'h0);
    #1 arst_n = 1'b1;
    sb.push_back('{data: 16'h0F0F, mod: 4'd0});
    send_word(16'h0F0F, 16);
    idle(3);

    check("pending", 32'(sb.size()), 32'd0);
    check("total_strobes", 32'(strobes), 32'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
